// File: rtl/filt_out_requant.sv
// Requantizer for the FIR output: round-half-up, arithmetic shift, saturate to OUT_W, then FWFT FIFO.
// Optional statistics counters are built when FILT_REQUANT_STATS_EN is defined.
module filt_out_requant #(
  parameter int unsigned IN_W  = 111,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 30,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             clr_flags,
  output logic [15:0]      sat_count,
  output logic [15:0]      drop_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [IN_W:0]    RND     = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Rounding add is one bit wider than the input so it cannot wrap
  logic signed [IN_W:0] rnd_sum;
  logic signed [IN_W:0] rnd_shr;
  assign rnd_sum = $signed({in_data[IN_W-1], in_data}) + $signed(RND);
  assign rnd_shr = rnd_sum >>> SHIFT;

  logic                 s1_valid;
  logic signed [IN_W:0] s1_r;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid) s1_r <= rnd_shr;
  end

  // Clamp when the bits above the output sign are not a pure sign extension
  logic             pos_ovf;
  logic             neg_ovf;
  logic [OUT_W-1:0] sat_val;

  always_comb begin
    pos_ovf = !s1_r[IN_W] && (|s1_r[IN_W:OUT_W-1]);
    neg_ovf =  s1_r[IN_W] && !(&s1_r[IN_W:OUT_W-1]);
    sat_val = s1_r[OUT_W-1:0];
    if (pos_ovf)      sat_val = SAT_MAX;
    else if (neg_ovf) sat_val = SAT_MIN;
  end

  logic             s2_valid;
  logic [OUT_W-1:0] s2_data;

  always_ff @(posedge clk) begin
    if (rst) s2_valid <= 1'b0;
    else     s2_valid <= s1_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_valid) s2_data <= sat_val;
  end

  // FIFO control
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [OUT_W-1:0] head_next;
  logic             rd_en;
  logic             wr_en;
  logic             drop;
  logic             full;

  always_comb begin
    rd_en       = out_valid && out_ready;
    full        = (count == CW'(DEPTH));
    wr_en       = s2_valid && (!full || rd_en);
    drop        = s2_valid && !wr_en;
    rd_ptr_next = rd_en ? rd_ptr + AW'(1) : rd_ptr;
    count_next  = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    // Bypass the word being written when it becomes the new head
    head_next = mem[rd_ptr_next];
    if (wr_en && (rd_ptr_next == wr_ptr)) head_next = s2_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s2_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (count_next != '0) out_data <= head_next;
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
    end
  end

`ifdef FILT_REQUANT_STATS_EN
  logic             s2_sat;
  logic [CNT_W-1:0] sat_base;
  logic [CNT_W-1:0] drop_base;

  always_ff @(posedge clk) begin
    if (rst) s2_sat <= 1'b0;
    else     s2_sat <= s1_valid && (pos_ovf || neg_ovf);
  end

  // A clear and an event in the same cycle leaves the counter at 1
  assign sat_base  = clr_flags ? '0 : sat_count;
  assign drop_base = clr_flags ? '0 : drop_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      if (s2_sat && (sat_base != {CNT_W{1'b1}})) sat_count <= sat_base + CNT_W'(1);
      else                                       sat_count <= sat_base;
      if (drop && (drop_base != {CNT_W{1'b1}}))  drop_count <= drop_base + CNT_W'(1);
      else                                       drop_count <= drop_base;
    end
  end
`else
  assign sat_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_filt_out_requant.sv
// Bench for filt_out_requant at SHIFT=4, DEPTH=8: vector table, scoreboard queue, and
// hand sequences for latency, overflow, full read/write, clear and reset.
module tb_filt_out_requant;

  localparam int IN_W  = 111;
  localparam int OUT_W = 16;

`ifdef FILT_REQUANT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             clr_flags;
  logic [15:0]      sat_count;
  logic [15:0]      drop_count;

  always #5 clk = ~clk;

  filt_out_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .clr_flags(clr_flags),
    .sat_count(sat_count), .drop_count(drop_count)
  );

  typedef struct {
    longint din;
    int     dout;
    bit     sat;
  } vec_t;

  vec_t        vt[10];
  logic [15:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint v);
    in_data  = {{47{v[63]}}, v};
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 60) begin
      cyc();
      i++;
    end
    chk(name, exp_q.size(), 0);
    repeat (2) cyc();
  endtask

  // Scoreboard: every accepted output word must match the oldest expected word
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %0d, expected no word", $signed(out_data));
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %0d, expected %0d", $signed(out_data), $signed(e));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n_sat;
    bit seen;

    vt[0] = '{40, 3, 1'b0};
    vt[1] = '{39, 2, 1'b0};
    vt[2] = '{-40, -2, 1'b0};
    vt[3] = '{-41, -3, 1'b0};
    vt[4] = '{8, 1, 1'b0};
    vt[5] = '{-8, 0, 1'b0};
    vt[6] = '{524272, 32767, 1'b0};
    vt[7] = '{524280, 32767, 1'b1};
    vt[8] = '{-524288, -32768, 1'b0};
    vt[9] = '{-524297, -32768, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_flags = 1'b0;
    repeat (3) cyc();
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'($signed(out_data)), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_sat_count", int'(sat_count), 0);
    chk("reset_drop_count", int'(drop_count), 0);
    rst = 1'b0;
    cyc();

    // Single sample latency
    exp_q.push_back(16'(3));
    in_data = 111'(40); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    chk("latency_edges", lat, 3);
    wait_drain("drain_latency");

    // Rounding and saturation boundary table, back to back
    n_sat = 0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(16'(vt[i].dout));
      if (vt[i].sat) n_sat++;
      send(vt[i].din);
    end
    wait_drain("drain_table");
    chk("table_sat_count", int'(sat_count), STATS ? n_sat : 0);

    // Saturation scenario
    pulse_clr();
    chk("clr_sat_count", int'(sat_count), 0);
    exp_q.push_back(16'(32767));
    send(longint'(1) << 20);
    exp_q.push_back(16'(-32768));
    send(-(longint'(1) << 20));
    wait_drain("drain_sat");
    chk("sat_count_two", int'(sat_count), STATS ? 2 : 0);

    // Overflow: ten samples into a stalled eight-word FIFO
    pulse_clr();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) exp_q.push_back(16'(i));
      send(longint'(16 * i));
    end
    repeat (4) cyc();
    chk("ovf_overflow", int'(overflow), 1);
    chk("ovf_drop_count", int'(drop_count), STATS ? 2 : 0);
    chk("ovf_out_valid", int'(out_valid), 1);
    chk("ovf_head_stable", int'($signed(out_data)), 1);
    out_ready = 1'b1;
    wait_drain("drain_ovf");

    // Full FIFO with a read on the same edge as the write
    pulse_clr();
    out_ready = 1'b0;
    for (int i = 20; i <= 27; i++) begin
      exp_q.push_back(16'(i));
      send(longint'(16 * i));
    end
    repeat (4) cyc();
    chk("full_no_overflow", int'(overflow), 0);
    exp_q.push_back(16'(28));
    in_data = 111'(16 * 28); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    repeat (3) cyc();
    chk("full_rw_no_drop", int'(overflow), 0);
    chk("full_rw_drop_count", int'(drop_count), 0);
    // FIFO must still be full: one more sample is dropped
    send(longint'(16 * 99));
    repeat (4) cyc();
    chk("full_rw_still_full", int'(overflow), 1);
    chk("full_rw_drop_one", int'(drop_count), STATS ? 1 : 0);

    // Clear flags
    pulse_clr();
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_drop_count", int'(drop_count), 0);
    chk("clr_sat_count2", int'(sat_count), 0);
    out_ready = 1'b1;
    wait_drain("drain_full_rw");

    // Reset with three words queued and two in flight
    out_ready = 1'b0;
    send(longint'(16 * 50));
    send(longint'(16 * 51));
    send(longint'(16 * 52));
    repeat (3) cyc();
    chk("pre_reset_valid", int'(out_valid), 1);
    send(longint'(16 * 53));
    send(longint'(16 * 54));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("post_reset_valid", int'(out_valid), 0);
    chk("post_reset_data", int'($signed(out_data)), 0);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("post_reset_nothing", int'(seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
